// File: rtl/jtframe_z80_romcache.sv
// rtl/jtframe_z80_romcache.sv - direct-mapped 16-bit-line ROM cache between Z80 fetch port and SDRAM slot
// Optional hit/miss statistics counters enabled by defining JTFRAME_ROMCACHE_STATS_EN.
module jtframe_z80_romcache #(
    parameter int AW    = 15,
    parameter int IDX_W = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr,
    input  logic          rom_cs,
    output logic          rom_ok,
    output logic [7:0]    rom_dout,
    input  logic          flush,
    output logic [AW-2:0] sdram_addr,
    output logic          sdram_cs,
    input  logic          sdram_ok,
    input  logic [15:0]   sdram_data,
    output logic [15:0]   hit_cnt,
    output logic [15:0]   miss_cnt
);
    localparam int LINES = 1 << IDX_W;
    localparam int TW    = AW - 1 - IDX_W;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOOKUP = 2'd1;
    localparam logic [1:0] ST_FILL   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    addr_l_q, addr_l_d;
    logic             ok_r_q, ok_r_d;
    logic [7:0]       dout_q, dout_d;
    logic             sdram_cs_q, sdram_cs_d;
    logic [AW-2:0]    sdram_addr_q, sdram_addr_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic             kill_q, kill_d;

    logic [TW-1:0]    tag_mem  [LINES];
    logic [15:0]      data_mem [LINES];

    logic [IDX_W-1:0] idx;
    logic [TW-1:0]    ltag;
    logic             addr_match, hit, wr_en, lookup_hit, lookup_miss;
    logic [15:0]      line_word;

    assign idx        = addr_l_q[IDX_W:1];
    assign ltag       = addr_l_q[AW-1:IDX_W+1];
    assign addr_match = (addr == addr_l_q);
    assign line_word  = data_mem[idx];
    assign hit        = valid_q[idx] && (tag_mem[idx] == ltag);

    // The registered flag is only honoured while the CPU still asks for the same byte.
    assign rom_ok     = ok_r_q & rom_cs & addr_match;
    assign rom_dout   = dout_q;
    assign sdram_cs   = sdram_cs_q;
    assign sdram_addr = sdram_addr_q;

    always_comb begin
        state_d      = state_q;
        addr_l_d     = addr_l_q;
        ok_r_d       = ok_r_q & rom_cs & addr_match;
        dout_d       = dout_q;
        sdram_cs_d   = sdram_cs_q;
        sdram_addr_d = sdram_addr_q;
        valid_d      = valid_q;
        kill_d       = kill_q;
        wr_en        = 1'b0;
        lookup_hit   = 1'b0;
        lookup_miss  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rom_cs && !rom_ok) begin
                    addr_l_d = addr;
                    ok_r_d   = 1'b0;
                    state_d  = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (hit && !flush) begin
                    ok_r_d     = 1'b1;
                    dout_d     = addr_l_q[0] ? line_word[15:8] : line_word[7:0];
                    lookup_hit = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    sdram_addr_d = addr_l_q[AW-1:1];
                    sdram_cs_d   = 1'b1;
                    kill_d       = 1'b0;
                    lookup_miss  = 1'b1;
                    state_d      = ST_FILL;
                end
            end
            ST_FILL: begin
                if (flush) kill_d = 1'b1;
                if (sdram_ok) begin
                    sdram_cs_d = 1'b0;
                    kill_d     = 1'b0;
                    state_d    = ST_IDLE;
                    // A flush seen at any point of the fill makes the returning word stale.
                    if (!kill_q && !flush) begin
                        wr_en        = 1'b1;
                        valid_d[idx] = 1'b1;
                        ok_r_d       = 1'b1;
                        dout_d       = addr_l_q[0] ? sdram_data[15:8] : sdram_data[7:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) valid_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_l_q     <= '0;
            ok_r_q       <= 1'b0;
            dout_q       <= 8'd0;
            sdram_cs_q   <= 1'b0;
            sdram_addr_q <= '0;
            valid_q      <= '0;
            kill_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_l_q     <= addr_l_d;
            ok_r_q       <= ok_r_d;
            dout_q       <= dout_d;
            sdram_cs_q   <= sdram_cs_d;
            sdram_addr_q <= sdram_addr_d;
            valid_q      <= valid_d;
            kill_q       <= kill_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[idx]  <= ltag;
            data_mem[idx] <= sdram_data;
        end
    end

`ifdef JTFRAME_ROMCACHE_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (flush) begin
            hit_cnt_d  = 16'd0;
            miss_cnt_d = 16'd0;
        end else begin
            if (lookup_hit && hit_cnt_q != 16'hFFFF)   hit_cnt_d  = hit_cnt_q + 16'd1;
            if (lookup_miss && miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= 16'd0;
            miss_cnt_q <= 16'd0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = lookup_hit | lookup_miss;
    assign hit_cnt  = 16'd0;
    assign miss_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_jtframe_z80_romcache.sv
// tb/tb_jtframe_z80_romcache.sv - randomized bench for jtframe_z80_romcache against a direct-mapped cache model
`timescale 1ns/1ps
module tb_jtframe_z80_romcache;
`ifdef JTFRAME_ROMCACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [14:0] addr = '0;
    logic        rom_cs = 1'b0;
    logic        rom_ok;
    logic [7:0]  rom_dout;
    logic        flush = 1'b0;
    logic [13:0] sdram_addr;
    logic        sdram_cs;
    logic        sdram_ok;
    logic [15:0] sdram_data;
    logic [15:0] hit_cnt, miss_cnt;

    jtframe_z80_romcache #(.AW(15), .IDX_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .rom_cs(rom_cs), .rom_ok(rom_ok),
        .rom_dout(rom_dout), .flush(flush), .sdram_addr(sdram_addr), .sdram_cs(sdram_cs),
        .sdram_ok(sdram_ok), .sdram_data(sdram_data), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] rom [0:16383];
    int          sd_lat = 5;
    int          fill_cnt = 0;
    logic [13:0] last_fill_addr = '0;

    // reference: a direct-mapped cache of 64 one-word lines
    bit          m_valid [64];
    logic [7:0]  m_tag   [64];
    int          m_hits = 0;
    int          m_miss = 0;

    // SDRAM slot: answers sd_lat clocks after a request appears, holds ok until cs drops
    initial begin
        int  cnt;
        bit  prev_cs;
        cnt = 0;
        prev_cs = 1'b0;
        sdram_ok = 1'b0;
        sdram_data = 16'd0;
        forever begin
            @(posedge clk); #1;
            if (sdram_cs && !prev_cs) begin
                fill_cnt++;
                last_fill_addr = sdram_addr;
            end
            prev_cs = sdram_cs;
            if (!sdram_cs) begin
                cnt = 0;
                sdram_ok = 1'b0;
            end else begin
                cnt++;
                if (cnt >= sd_lat) begin
                    sdram_ok = 1'b1;
                    sdram_data = rom[sdram_addr];
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        m_hits = 0;
        m_miss = 0;
    endtask

    task automatic model_flush();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        m_hits = 0;
        m_miss = 0;
    endtask

    task automatic model_access(input logic [14:0] a, output logic [7:0] b, output bit hit);
        int          li;
        logic [15:0] w;
        li  = int'(a[6:1]);
        hit = m_valid[li] && (m_tag[li] == a[14:7]);
        if (hit) begin
            if (m_hits < 65535) m_hits++;
        end else begin
            if (m_miss < 65535) m_miss++;
            m_valid[li] = 1'b1;
            m_tag[li]   = a[14:7];
        end
        w = rom[a[14:1]];
        b = a[0] ? w[15:8] : w[7:0];
    endtask

    task automatic do_read(input logic [14:0] a, input int lat, output logic [7:0] data,
                           output int cyc, output int nfills, output bit seen);
        int f0;
        f0 = fill_cnt;
        sd_lat = lat;
        addr = a;
        rom_cs = 1'b1;
        cyc = 0;
        seen = 1'b0;
        while (cyc < 100 && !seen) begin
            @(posedge clk); #1;
            cyc++;
            seen = rom_ok;
        end
        data = rom_dout;
        rom_cs = 1'b0;
        @(posedge clk); #1;
        nfills = fill_cnt - f0;
    endtask

    task automatic wait_sdram_cs(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            seen = sdram_cs;
        end
    endtask

    task automatic test_reset();
        n_vec++;
        if (rom_ok !== 1'b0 || rom_dout !== 8'h00 || sdram_cs !== 1'b0 || sdram_addr !== 14'h0) begin
            n_err++;
            $display("FAIL reset_outputs: ok=%b dout=%h cs=%b saddr=%h required 0/00/0/0000",
                     rom_ok, rom_dout, sdram_cs, sdram_addr);
        end
        n_vec++;
        if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_counters: hit=%0d miss=%0d required 0/0", hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_cold_miss();
        logic [7:0] d, eb;
        int cyc, nf;
        bit seen, eh;
        rom[14'h0091] = 16'hBEEF;
        model_access(15'h0123, eb, eh);
        do_read(15'h0123, 5, d, cyc, nf, seen);
        n_vec++;
        if (!seen || d !== 8'hBE || cyc != 7) begin
            n_err++;
            $display("FAIL cold_miss_data: seen=%b dout=%h cycles=%0d required 1/BE/7", seen, d, cyc);
        end
        n_vec++;
        if (nf != 1 || last_fill_addr !== 14'h0091) begin
            n_err++;
            $display("FAIL cold_miss_fill: fills=%0d saddr=%h required 1/0091", nf, last_fill_addr);
        end
        n_vec++;
        if (sdram_cs !== 1'b0) begin
            n_err++;
            $display("FAIL cold_miss_cs_drop: sdram_cs=%b required 0", sdram_cs);
        end
        n_vec++;
        if (miss_cnt !== (STATS ? 16'(m_miss) : 16'd0)) begin
            n_err++;
            $display("FAIL cold_miss_cnt: miss_cnt=%0d required %0d", miss_cnt, STATS ? m_miss : 0);
        end
    endtask

    task automatic test_hit();
        logic [7:0] d, eb;
        int cyc, nf;
        bit seen, eh;
        model_access(15'h0122, eb, eh);
        do_read(15'h0122, 5, d, cyc, nf, seen);
        n_vec++;
        if (!seen || d !== 8'hEF || cyc != 2 || nf != 0) begin
            n_err++;
            $display("FAIL hit: seen=%b dout=%h cycles=%0d fills=%0d required 1/EF/2/0", seen, d, cyc, nf);
        end
        n_vec++;
        if (hit_cnt !== (STATS ? 16'(m_hits) : 16'd0)) begin
            n_err++;
            $display("FAIL hit_cnt: hit_cnt=%0d required %0d", hit_cnt, STATS ? m_hits : 0);
        end
    endtask

    task automatic test_conflict();
        logic [14:0] seq [3];
        logic [7:0] d, eb;
        int cyc, nf;
        bit seen, eh;
        seq[0] = 15'h0123; seq[1] = 15'h0923; seq[2] = 15'h0123;
        for (int i = 0; i < 3; i++) begin
            model_access(seq[i], eb, eh);
            do_read(seq[i], 3, d, cyc, nf, seen);
            n_vec++;
            if (!seen || d !== eb || nf != (eh ? 0 : 1)) begin
                n_err++;
                $display("FAIL conflict_%0d: seen=%b dout=%h fills=%0d required 1/%h/%0d",
                         i, seen, d, nf, eb, eh ? 0 : 1);
            end
        end
    endtask

    task automatic test_flush_fill();
        logic [7:0] d, eb;
        int cyc, nf, f0;
        bit seen, eh;
        f0 = fill_cnt;
        sd_lat = 6;
        addr = 15'h0040;
        rom_cs = 1'b1;
        wait_sdram_cs(seen);
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        model_flush();
        model_access(15'h0040, eb, eh);
        cyc = 0;
        seen = 1'b0;
        while (cyc < 60 && !seen) begin
            @(posedge clk); #1;
            cyc++;
            seen = rom_ok;
        end
        d = rom_dout;
        nf = fill_cnt - f0;
        rom_cs = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (!seen || nf != 2 || last_fill_addr !== 14'h0020 || d !== eb) begin
            n_err++;
            $display("FAIL flush_fill: seen=%b fills=%0d saddr=%h dout=%h required 1/2/0020/%h",
                     seen, nf, last_fill_addr, d, eb);
        end
        model_access(15'h0041, eb, eh);
        do_read(15'h0041, 6, d, cyc, nf, seen);
        n_vec++;
        if (!seen || d !== eb || nf != 0 || cyc != 2) begin
            n_err++;
            $display("FAIL flush_refill_hit: seen=%b dout=%h fills=%0d cycles=%0d required 1/%h/0/2",
                     seen, d, nf, cyc, eb);
        end
        n_vec++;
        if (hit_cnt !== (STATS ? 16'(m_hits) : 16'd0) || miss_cnt !== (STATS ? 16'(m_miss) : 16'd0)) begin
            n_err++;
            $display("FAIL flush_counters: hit=%0d miss=%0d required %0d/%0d",
                     hit_cnt, miss_cnt, STATS ? m_hits : 0, STATS ? m_miss : 0);
        end
    endtask

    task automatic test_addr_change();
        logic [7:0] d, eb, eb0;
        int cyc, nf, f0;
        bit seen, eh, early;
        f0 = fill_cnt;
        sd_lat = 4;
        model_access(15'h0010, eb0, eh);
        model_access(15'h0200, eb, eh);
        addr = 15'h0010;
        rom_cs = 1'b1;
        wait_sdram_cs(seen);
        @(posedge clk); #1;
        addr = 15'h0200;
        cyc = 0;
        seen = 1'b0;
        early = 1'b0;
        while (cyc < 60 && !seen) begin
            @(posedge clk); #1;
            cyc++;
            seen = rom_ok;
            if (seen && fill_cnt - f0 < 2) early = 1'b1;
        end
        d = rom_dout;
        nf = fill_cnt - f0;
        rom_cs = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (!seen || early || nf != 2 || last_fill_addr !== 14'h0100 || d !== eb) begin
            n_err++;
            $display("FAIL addr_change: seen=%b early=%b fills=%0d saddr=%h dout=%h required 1/0/2/0100/%h",
                     seen, early, nf, last_fill_addr, d, eb);
        end
        model_access(15'h0011, eb, eh);
        do_read(15'h0011, 4, d, cyc, nf, seen);
        n_vec++;
        if (!seen || d !== eb || nf != 0) begin
            n_err++;
            $display("FAIL addr_change_old_cached: seen=%b dout=%h fills=%0d required 1/%h/0", seen, d, nf, eb);
        end
    endtask

    task automatic test_random();
        logic [14:0] a;
        logic [7:0] d, eb;
        int cyc, nf, lat;
        bit seen, eh;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
                model_flush();
            end
            a   = {8'($urandom_range(0, 2)), 6'($urandom_range(0, 7)), 1'($urandom)};
            lat = $urandom_range(1, 4);
            model_access(a, eb, eh);
            do_read(a, lat, d, cyc, nf, seen);
            n_vec++;
            if (!seen || d !== eb || nf != (eh ? 0 : 1) || cyc != (eh ? 2 : 2 + lat)) begin
                n_err++;
                $display("FAIL random_%0d addr=%h: seen=%b dout=%h fills=%0d cycles=%0d required 1/%h/%0d/%0d",
                         i, a, seen, d, nf, cyc, eb, eh ? 0 : 1, eh ? 2 : 2 + lat);
            end
        end
        n_vec++;
        if (hit_cnt !== (STATS ? 16'(m_hits) : 16'd0) || miss_cnt !== (STATS ? 16'(m_miss) : 16'd0)) begin
            n_err++;
            $display("FAIL random_counters: hit=%0d miss=%0d required %0d/%0d",
                     hit_cnt, miss_cnt, STATS ? m_hits : 0, STATS ? m_miss : 0);
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [7:0] d, eb;
        int cyc, nf;
        bit seen, eh;
        model_access(15'h0122, eb, eh);
        do_read(15'h0122, 3, d, cyc, nf, seen);
        sd_lat = 8;
        addr = 15'h3000;
        rom_cs = 1'b1;
        wait_sdram_cs(seen);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (!seen || sdram_cs !== 1'b0 || rom_ok !== 1'b0 || sdram_addr !== 14'h0) begin
            n_err++;
            $display("FAIL reset_mid_fill: cs_seen=%b sdram_cs=%b rom_ok=%b saddr=%h required 1/0/0/0000",
                     seen, sdram_cs, rom_ok, sdram_addr);
        end
        rom_cs = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        model_access(15'h0122, eb, eh);
        do_read(15'h0122, 3, d, cyc, nf, seen);
        n_vec++;
        if (!seen || d !== eb || nf != 1 || eh) begin
            n_err++;
            $display("FAIL reset_then_miss: seen=%b dout=%h fills=%0d required 1/%h/1", seen, d, nf, eb);
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) rom[i] = 16'($urandom);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush_fill();
        test_addr_change();
        test_random();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
